// File: rtl/multi_ch_timer.sv
// Multi-channel programmable interval timer: per-channel power-of-two period,
// periodic or one-shot mode, one-cycle tick, sticky irq with clear, busy status.
module multi_ch_timer #(
   parameter int NUM_CH     = 4,
   parameter int SEL_W      = 3,
   parameter int BASE_SHIFT = 6,
   parameter int CNT_W      = 13
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       ch_en,
   input  logic [NUM_CH-1:0]       ch_start,
   input  logic [NUM_CH-1:0]       ch_mode,
   input  logic [NUM_CH*SEL_W-1:0] ch_sel,
   input  logic [NUM_CH-1:0]       irq_clr,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       irq,
   output logic [NUM_CH-1:0]       busy,
   output logic                    any_irq
);

   if (CNT_W < BASE_SHIFT + (1 << SEL_W) - 1) begin : g_cnt_w_check
      $fatal(1, "multi_ch_timer: CNT_W too small for the longest period");
   end
   if (NUM_CH < 1 || NUM_CH > 16) begin : g_num_ch_check
      $fatal(1, "multi_ch_timer: NUM_CH must be 1..16");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state   [NUM_CH];
   state_t           state_n [NUM_CH];
   logic [CNT_W-1:0] cnt     [NUM_CH];
   logic [CNT_W-1:0] cnt_n   [NUM_CH];
   logic [SEL_W-1:0] sel_l   [NUM_CH];
   logic [SEL_W-1:0] sel_n   [NUM_CH];
   logic [NUM_CH-1:0] mode_l, mode_n, tick_n, irq_n;

   // Terminal count P-1 as a low-bit mask; a shift equal to CNT_W yields all ones.
   function automatic logic [CNT_W-1:0] term_count(input logic [SEL_W-1:0] s);
      return ~({CNT_W{1'b1}} << (BASE_SHIFT + int'(s)));
   endfunction

   always_comb begin
      mode_n = mode_l;
      tick_n = '0;
      irq_n  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         state_n[i] = state[i];
         cnt_n[i]   = cnt[i];
         sel_n[i]   = sel_l[i];
         // Enable low overrides start and terminal; start overrides terminal.
         if (!ch_en[i]) begin
            state_n[i] = IDLE;
            cnt_n[i]   = '0;
         end else if (ch_start[i]) begin
            state_n[i] = RUN;
            cnt_n[i]   = '0;
            sel_n[i]   = ch_sel[i*SEL_W +: SEL_W];
            mode_n[i]  = ch_mode[i];
         end else if (state[i] == RUN) begin
            if (cnt[i] == term_count(sel_l[i])) begin
               cnt_n[i]  = '0;
               tick_n[i] = 1'b1;
               if (mode_l[i]) state_n[i] = IDLE;
               else           sel_n[i]   = ch_sel[i*SEL_W +: SEL_W];
            end else begin
               cnt_n[i] = cnt[i] + CNT_W'(1);
            end
         end
         irq_n[i] = tick_n[i] | (irq[i] & ~irq_clr[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
            sel_l[i] <= '0;
         end
         mode_l <= '0;
         tick   <= '0;
         irq    <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state[i] <= state_n[i];
            cnt[i]   <= cnt_n[i];
            sel_l[i] <= sel_n[i];
         end
         mode_l <= mode_n;
         tick   <= tick_n;
         irq    <= irq_n;
      end
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < NUM_CH; i++) busy[i] = (state[i] == RUN);
   end

   assign any_irq = |irq;

endmodule
